// File: rtl/half_adder_unit_pkg.sv
// Shared constants for the registered half-adder unit.
package half_adder_unit_pkg;

   localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/half_adder_unit_if.sv
// Operand/result bundle for half_adder_unit.
// The master drives the operands and the slave returns the registered results.
interface half_adder_unit_if
   import half_adder_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] c;
   logic             out_valid;

   modport master (
      output in_valid,
      output a,
      output b,
      input  s,
      input  c,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      output s,
      output c,
      output out_valid
   );

endinterface

// File: rtl/half_adder_unit_cell.sv
// Purely combinational 1-bit half adder.
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/half_adder_unit.sv
// WIDTH independent half-adder lanes with a one-cycle registered output.
// There is no carry propagation between lanes.
module half_adder_unit
   import half_adder_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              rst,
   half_adder_unit_if.slave bus
);

   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] carry_w;
   logic [WIDTH-1:0] s_d;
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] c_d;
   logic [WIDTH-1:0] c_q;
   logic             out_valid_d;
   logic             out_valid_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a (bus.a[i]),
         .b (bus.b[i]),
         .s (sum_w[i]),
         .c (carry_w[i])
      );
   end

   // Results only load on a valid input, so X operands while idle never reach the flops.
   always_comb begin
      s_d         = s_q;
      c_d         = c_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         s_d         = sum_w;
         c_d         = carry_w;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q         <= '0;
         c_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.s         = s_q;
   assign bus.c         = c_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed and random checks of half_adder_unit at WIDTH 1, 8 and 16.
module tb_half_adder_unit;

   logic clk;
   logic rst;
   int   cmp_count;
   int   err_count;

   half_adder_unit_if #(.WIDTH(1))  bus1 ();
   half_adder_unit_if #(.WIDTH(8))  bus8 ();
   half_adder_unit_if #(.WIDTH(16)) bus16 ();

   half_adder_unit #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(bus1));
   half_adder_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
   half_adder_unit #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_count++;
      assert (obs === exp) else begin
         err_count++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  vec_a;
      logic [1:0]  vec_b;
      logic [1:0]  vec_s;
      logic [1:0]  vec_c;
      logic        rv;
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] exp_s16;
      logic [15:0] exp_c16;
      logic        exp_v16;

      cmp_count = 0;
      err_count = 0;
      rst = 1'b1;
      bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;

      tick();
      tick();
      check("rst_s1",  64'(bus1.s), 64'd0);
      check("rst_c1",  64'(bus1.c), 64'd0);
      check("rst_ov1", 64'(bus1.out_valid), 64'd0);
      check("rst_ov8", 64'(bus8.out_valid), 64'd0);
      rst = 1'b0;

      // Truth table on consecutive edges: (a,b) 00,01,10,11 -> (s,c) 00,10,10,01
      vec_a = 2'b00; vec_b = 2'b00; vec_s = 2'b00; vec_c = 2'b00;
      for (int i = 0; i < 4; i++) begin
         vec_a = 2'(i >> 1);
         vec_b = 2'(i & 1);
         bus1.in_valid = 1'b1;
         bus1.a = vec_a[0];
         bus1.b = vec_b[0];
         tick();
         vec_s = (i == 1 || i == 2) ? 2'd1 : 2'd0;
         vec_c = (i == 3) ? 2'd1 : 2'd0;
         check($sformatf("tt_s_%0d", i),  64'(bus1.s), 64'(vec_s));
         check($sformatf("tt_c_%0d", i),  64'(bus1.c), 64'(vec_c));
         check($sformatf("tt_ov_%0d", i), 64'(bus1.out_valid), 64'd1);
      end

      bus1.in_valid = 1'b0;
      bus1.a = 1'b0;
      bus1.b = 1'b0;
      tick();
      check("idle_ov1", 64'(bus1.out_valid), 64'd0);
      check("idle_c1_hold", 64'(bus1.c), 64'd1);

      // Asynchronous reset between edges clears outputs without a clock edge
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
      tick();
      check("pre_async_ov1", 64'(bus1.out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_s1",  64'(bus1.s), 64'd0);
      check("async_c1",  64'(bus1.c), 64'd0);
      check("async_ov1", 64'(bus1.out_valid), 64'd0);

      // Input presented while reset is held is discarded
      tick();
      check("rst_discard_ov1", 64'(bus1.out_valid), 64'd0);
      check("rst_discard_c1",  64'(bus1.c), 64'd0);
      rst = 1'b0;
      bus1.in_valid = 1'b0;
      tick();
      check("post_rst_ov1", 64'(bus1.out_valid), 64'd0);
      check("post_rst_s1",  64'(bus1.s), 64'd0);
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
      tick();
      check("post_rst_valid_s1",  64'(bus1.s), 64'd1);
      check("post_rst_valid_c1",  64'(bus1.c), 64'd0);
      check("post_rst_valid_ov1", 64'(bus1.out_valid), 64'd1);
      bus1.in_valid = 1'b0;

      bus8.in_valid = 1'b1; bus8.a = 8'hF0; bus8.b = 8'hCC;
      tick();
      check("w8_s",  64'(bus8.s), 64'h3C);
      check("w8_c",  64'(bus8.c), 64'hC0);
      check("w8_ov", 64'(bus8.out_valid), 64'd1);

      bus8.a = 8'hFF; bus8.b = 8'h01;
      tick();
      check("w8_ff_s",  64'(bus8.s), 64'hFE);
      check("w8_ff_c",  64'(bus8.c), 64'h01);
      check("w8_ff_ov", 64'(bus8.out_valid), 64'd1);

      // Idle cycles with junk (including X) operands must leave results untouched
      bus8.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            bus8.a = 'x;
            bus8.b = 'x;
         end else begin
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
         end
         tick();
         check($sformatf("w8_hold_s_%0d", i),  64'(bus8.s), 64'hFE);
         check($sformatf("w8_hold_c_%0d", i),  64'(bus8.c), 64'h01);
         check($sformatf("w8_hold_ov_%0d", i), 64'(bus8.out_valid), 64'd0);
      end
      bus8.a = '0;
      bus8.b = '0;

      exp_s16 = '0;
      exp_c16 = '0;
      exp_v16 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         rv = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         bus16.in_valid = rv;
         bus16.a = ra;
         bus16.b = rb;
         if (rv) begin
            exp_s16 = ra ^ rb;
            exp_c16 = ra & rb;
         end
         exp_v16 = rv;
         tick();
         check("w16_ov", 64'(bus16.out_valid), 64'(exp_v16));
         check("w16_s",  64'(bus16.s), 64'(exp_s16));
         check("w16_c",  64'(bus16.c), 64'(exp_c16));
         check("w16_sc_excl", 64'(bus16.s & bus16.c), 64'd0);
      end
      bus16.in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
